// File: rtl/spram_arb_pkg.sv
// -----------------------------------------------------------------------------
// spram_arb_pkg
// Shared definitions for the two-port SPRAM arbiter:
//   AW          SPRAM word-address width (byte address bits [16:2])
//   P_CPU/P_AUX port indices (0 = FemtoRV32 bus, 1 = auxiliary master)
//   req_t       one access request: address, write data, byte mask, read flag
//   grant_e     per-cycle grant: nobody, port 0 or port 1
// -----------------------------------------------------------------------------
package spram_arb_pkg;

    localparam int AW    = 15;
    localparam int P_CPU = 0;
    localparam int P_AUX = 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        logic          is_read;
    } req_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_P0   = 2'd1,
        GNT_P1   = 2'd2
    } grant_e;

endpackage

// File: rtl/spram_arb_port.sv
// -----------------------------------------------------------------------------
// spram_arb_port
// Per-port front end of the SPRAM arbiter. Turns the native strobe/busy bus
// into a request for the grant logic, parks a losing request in a one-deep
// latch, and returns read data with a hold register so rdata stays stable
// until the port's next read completes.
// Ports:
//   clk, resetq      clock, asynchronous active-low reset
//   addr_i..rstrb_i  the master's live bus signals
//   grant_i          this port owns the SPRAM in the current cycle
//   ram_rdata_i      SPRAM read data (valid one cycle after its address)
//   req_o            effective request (latched one if pending, else live)
//   live_o           a live strobe is being accepted this cycle
//   pend_o           a latched request is waiting
//   rdata_o          read data to the master
//   rbusy_o/wbusy_o  pending read / pending write
// -----------------------------------------------------------------------------
module spram_arb_port
    import spram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          resetq,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    wmask_i,
    input  logic          rstrb_i,
    input  logic          grant_i,
    input  logic [31:0]   ram_rdata_i,
    output req_t          req_o,
    output logic          live_o,
    output logic          pend_o,
    output logic [31:0]   rdata_o,
    output logic          rbusy_o,
    output logic          wbusy_o
);

    logic        liveWrite;
    req_t        liveReq;
    logic        pend_q, pend_d;
    req_t        latch_q, latch_d;
    logic        rdv_q, rdv_d;
    logic [31:0] hold_q;

    // A nonzero mask makes it a write even if rstrb is also high. While a
    // request is already latched, new strobes are a protocol violation and
    // are simply not accepted.
    assign liveWrite = |wmask_i;
    assign live_o    = (liveWrite | rstrb_i) & ~pend_q;

    // Live request as seen on the bus this cycle
    always_comb begin
        liveReq.addr    = addr_i;
        liveReq.wdata   = wdata_i;
        liveReq.wmask   = wmask_i;
        liveReq.is_read = ~liveWrite;
    end

    assign req_o  = pend_q ? latch_q : liveReq;
    assign pend_o = pend_q;

    // Latch control: a granted pending request retires; a live strobe that
    // lost arbitration is parked for the next cycle.
    always_comb begin
        pend_d  = pend_q;
        latch_d = latch_q;
        if (pend_q && grant_i) begin
            pend_d = 1'b0;
        end else if (live_o && !grant_i) begin
            pend_d  = 1'b1;
            latch_d = liveReq;
        end
    end

    // Read data arrives from the SPRAM the cycle after a granted read
    assign rdv_d = grant_i & (pend_q | live_o) & req_o.is_read;

    // Latch, read-valid flag and read-data hold register
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            pend_q  <= 1'b0;
            latch_q <= '0;
            rdv_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            latch_q <= latch_d;
            rdv_q   <= rdv_d;
            if (rdv_q) begin
                hold_q <= ram_rdata_i;
            end
        end
    end

    assign rdata_o = rdv_q ? ram_rdata_i : hold_q;

    // Busy is the latch state itself, so it is high for exactly the cycle
    // the parked request is being served.
    assign rbusy_o = pend_q & latch_q.is_read;
    assign wbusy_o = pend_q & ~latch_q.is_read;

endmodule

// File: rtl/spram_arbiter.sv
// -----------------------------------------------------------------------------
// spram_arbiter
// Shares a single ice40up5k SPRAM between the FemtoRV32 bus (port 0) and a
// second bus master (port 1). Uncontested accesses pass straight through with
// zero wait states; a loser is latched and served on the following cycle.
// Configuration macro:
//   SPRAM_ARBITER_RR_EN  defined   -> simultaneous strobes alternate
//                                     (port 1 wins the first contest)
//                        undefined -> port 0 always wins simultaneous strobes
// Ports:
//   clk, resetq                         12 MHz clock, async active-low reset
//   pN_addr/wdata/wmask/rstrb (N=0,1)   master request signals
//   pN_rdata, pN_rbusy, pN_wbusy        master response signals
//   ram_addr, ram_wdata, ram_wen        SPRAM request side
//   ram_rdata                           SPRAM read data
// -----------------------------------------------------------------------------
module spram_arbiter
    import spram_arb_pkg::*;
(
    input  logic          clk,
    input  logic          resetq,
    input  logic [AW-1:0] p0_addr,
    input  logic [31:0]   p0_wdata,
    input  logic [3:0]    p0_wmask,
    input  logic          p0_rstrb,
    output logic [31:0]   p0_rdata,
    output logic          p0_rbusy,
    output logic          p0_wbusy,
    input  logic [AW-1:0] p1_addr,
    input  logic [31:0]   p1_wdata,
    input  logic [3:0]    p1_wmask,
    input  logic          p1_rstrb,
    output logic [31:0]   p1_rdata,
    output logic          p1_rbusy,
    output logic          p1_wbusy,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_wen,
    input  logic [31:0]   ram_rdata
);

    req_t          req0, req1, selReq;
    logic          live0, live1;
    logic          pend0, pend1;
    grant_e        grant;
    logic          granted;
    logic [AW-1:0] addr_q;

    spram_arb_port u_port0 (
        .clk         (clk),
        .resetq      (resetq),
        .addr_i      (p0_addr),
        .wdata_i     (p0_wdata),
        .wmask_i     (p0_wmask),
        .rstrb_i     (p0_rstrb),
        .grant_i     (grant == GNT_P0),
        .ram_rdata_i (ram_rdata),
        .req_o       (req0),
        .live_o      (live0),
        .pend_o      (pend0),
        .rdata_o     (p0_rdata),
        .rbusy_o     (p0_rbusy),
        .wbusy_o     (p0_wbusy)
    );

    spram_arb_port u_port1 (
        .clk         (clk),
        .resetq      (resetq),
        .addr_i      (p1_addr),
        .wdata_i     (p1_wdata),
        .wmask_i     (p1_wmask),
        .rstrb_i     (p1_rstrb),
        .grant_i     (grant == GNT_P1),
        .ram_rdata_i (ram_rdata),
        .req_o       (req1),
        .live_o      (live1),
        .pend_o      (pend1),
        .rdata_o     (p1_rdata),
        .rbusy_o     (p1_rbusy),
        .wbusy_o     (p1_wbusy)
    );

`ifdef SPRAM_ARBITER_RR_EN
    // last_winner_q = 1 means port 1 won the most recent contest. Reset to 0
    // so port 1 takes the first contest. live_o already excludes pending
    // ports, so both lives high is exactly a contested cycle.
    logic last_winner_q;
    logic contested;

    assign contested = live0 & live1;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            last_winner_q <= 1'b0;
        end else if (contested) begin
            last_winner_q <= (grant == GNT_P1);
        end
    end
`endif

    // Grant: a parked request always goes first (at most one can exist),
    // then live strobes, with the tie-break selected by the build option.
    always_comb begin
        grant = GNT_NONE;
        if (pend0) begin
            grant = GNT_P0;
        end else if (pend1) begin
            grant = GNT_P1;
        end else if (live0 && live1) begin
`ifdef SPRAM_ARBITER_RR_EN
            grant = last_winner_q ? GNT_P0 : GNT_P1;
`else
            grant = GNT_P0;
`endif
        end else if (live0) begin
            grant = GNT_P0;
        end else if (live1) begin
            grant = GNT_P1;
        end
    end

    // SPRAM request mux
    always_comb begin
        selReq = req0;
        if (grant == GNT_P1) begin
            selReq = req1;
        end
    end

    assign granted   = (grant != GNT_NONE);
    assign ram_addr  = granted ? selReq.addr : addr_q;
    assign ram_wdata = granted ? selReq.wdata : 32'h0;
    assign ram_wen   = (granted && !selReq.is_read) ? selReq.wmask : 4'h0;

    // Idle cycles keep presenting the last granted address
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            addr_q <= '0;
        end else if (granted) begin
            addr_q <= selReq.addr;
        end
    end

endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Two-port arbiter sharing the single ice40up5k_spram instance between the FemtoRV32 bus (port 0) and a second bus master such as a DMA or video fetch unit (port 1). Each port uses the processor's native strobe/busy protocol. An uncontested access completes with zero wait states, identical to a direct SPRAM connection. A losing request is latched and served on the next cycle, and the port's busy flag stalls it in the meantime. The block sits between the bus decode (`mem_address_is_ram`) and the SPRAM primitive.

## Interface
- `AW`, 15: SPRAM word-address width (byte address bits [16:2]).
- `clk` in 1: system clock, 12 MHz.
- `resetq` in 1: reset, asynchronous and active-low.
- `pN_addr` in AW (N = 0, 1): word address.
- `pN_wdata` in 32: write data.
- `pN_wmask` in 4: byte write strobes. Nonzero for one cycle starts a write.
- `pN_rstrb` in 1: one-cycle read strobe.
- `pN_rdata` out 32: read data.
- `pN_rbusy` out 1: read pending.
- `pN_wbusy` out 1: write pending.
- `ram_addr` out AW: SPRAM address.
- `ram_wdata` out 32: SPRAM write data.
- `ram_wen` out 4: SPRAM byte write enables.
- `ram_rdata` in 32: SPRAM read data, valid one cycle after its address.

## Operation
- **Per-port request.** A request is either a live strobe (`rstrb` or `|wmask`) or a pending latch.
  - If `rstrb` and `wmask` are both asserted in the same cycle, the write wins and the read is dropped.
  - A strobe arriving while the same port already has a pending request violates the protocol and is ignored.
- **Grant, each cycle, combinational.**
  - A pending request beats any live strobe.
  - Two pending requests cannot coexist.
  - Two live strobes in the same cycle: port 0 wins (default), or round-robin under the macro (see Configuration).
- **Granted port.** `ram_addr`, `ram_wdata` and `ram_wen` are driven from the live inputs or from the latch; `ram_wen` = 0 for reads.
- **Idle cycle.** `ram_wen` = 0 and `ram_addr` holds the last granted address.
- **Losing live strobe.** addr, wdata, wmask and the read/write type are captured into that port's latch.
- **Read return.**
  - A registered flag `rdv_N` is set in the cycle after a read granted to port N.
  - `pN_rdata` = `rdv_N` ? `ram_rdata` : `hold_N`.
  - `hold_N` captures `ram_rdata` whenever `rdv_N` is set, so data stays stable until the port's next read returns.
- **Writes.** Completed at grant; no return path.

## Timing
- **Reset.** All outputs 0, latches empty, `rdv_N` = 0, `hold_N` = 0. An asynchronous reset mid-request discards pending requests without issuing them.
- **Uncontested read.** Strobe at T, `ram_addr` at T, `pN_rdata` valid at T+1. `rbusy` is never asserted.
- **Uncontested write.** SPRAM written at T's edge. `wbusy` is never asserted.
- **Contested (loser strobes at T).**
  - Latch is set at T's edge and the loser is served at S = T+1.
  - `pN_rbusy` / `pN_wbusy` are high for exactly cycle T+1; the busy flag equals the latch state, registered.
  - Read data is valid at S+1 = T+2, the first cycle with busy low.
- **Worst-case wait.** One cycle per access. Neither port starves.
- **Back-to-back strobes from the winner.** They continue to be granted while the other port has no pending request. When the other port has a pending request, the pending request wins and the winner becomes the loser for that cycle.

## Configuration
- `SPRAM_ARBITER_RR_EN` defined: simultaneous live strobes use round-robin. A `last_winner` register flips on every contested cycle, and port 1 wins first after reset.
- Undefined: port 0 always wins simultaneous strobes. `last_winner` is not implemented.

## Structure
- **Package `spram_arb_pkg`.** Holds:
  - `AW` default;
  - port index constants `P_CPU` = 0 and `P_AUX` = 1;
  - the `req_t` struct: addr, wdata, wmask, is_read;
  - grant encoding: none, p0, p1.
- **Sub-module `spram_arb_port`.** Instantiated twice. It contains the pending latch, the busy outputs, `rdv_N` and the `hold_N` read-data register. The top level contains only the grant logic and the SPRAM muxes.

## Test plan
- **Solo read.** Preload word 0x0010 = 0xDEADBEEF; p0 read at T -> `p0_rdata` = 0xDEADBEEF at T+1, `p0_rbusy` low throughout.
- **Simultaneous writes, default build.** p0 writes 0x11111111 to 0x0020 and p1 writes 0x22222222 to 0x0021 at T -> `ram_wen` = 0xF on 0x0020 at T and on 0x0021 at T+1; `p1_wbusy` high only at T+1.
- **Simultaneous reads, `SPRAM_ARBITER_RR_EN` build.** First contest goes to p1 and the second to p0; the loser's `rbusy` is high one cycle and its data arrives at T+2.
- **Pending beats live strobe.** p1 pending at T+1 while p0 strobes again at T+1 -> p1 served at T+1, p0 latched and served at T+2.
- **Partial write.** p1 writes wmask 0b0100, wdata 0x00AB0000 to 0x0030, which holds 0x12345678 -> readback 0x12AB5678.
- **Reset mid-request.** `resetq` low during T+1 with p1 pending a write to 0x0040 -> no SPRAM write, `p1_wbusy` = 0, old data intact after release.
